// File: rtl/plug_pkg.sv
// rtl/plug_pkg.sv - shared letter types, FSM states and one-hot helper for the plugboard
package plug_pkg;

  localparam int NUM_LETTERS = 26;

  typedef logic [4:0] letter_idx_t;

  typedef enum logic {
    IDLE,
    HAVE_FIRST
  } cfg_state_t;

  function automatic logic [NUM_LETTERS-1:0] idx_to_onehot(input letter_idx_t idx);
    logic [NUM_LETTERS-1:0] oh;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      oh[i] = (idx == letter_idx_t'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/plugboard_pairs_if.sv
// rtl/plugboard_pairs_if.sv - letter streams, config controls and status of the plugboard
// PLUG_PENDING_EN adds the half-made plug indicator.
interface plugboard_pairs_if;
  import plug_pkg::*;

  logic                   cfg_mode;
  logic                   clear_pairs;
  logic [NUM_LETTERS-1:0] fwd_in;
  logic                   fwd_valid;
  logic [NUM_LETTERS-1:0] fwd_out;
  logic                   fwd_out_valid;
  logic [NUM_LETTERS-1:0] back_in;
  logic                   back_valid;
  logic [NUM_LETTERS-1:0] back_out;
  logic                   back_out_valid;
  logic [3:0]             pair_count;
  logic                   cfg_err;
`ifdef PLUG_PENDING_EN
  logic [NUM_LETTERS-1:0] pending;

  modport master (
    output cfg_mode, clear_pairs, fwd_in, fwd_valid, back_in, back_valid,
    input  fwd_out, fwd_out_valid, back_out, back_out_valid, pair_count, cfg_err, pending
  );
  modport slave (
    input  cfg_mode, clear_pairs, fwd_in, fwd_valid, back_in, back_valid,
    output fwd_out, fwd_out_valid, back_out, back_out_valid, pair_count, cfg_err, pending
  );
`else
  modport master (
    output cfg_mode, clear_pairs, fwd_in, fwd_valid, back_in, back_valid,
    input  fwd_out, fwd_out_valid, back_out, back_out_valid, pair_count, cfg_err
  );
  modport slave (
    input  cfg_mode, clear_pairs, fwd_in, fwd_valid, back_in, back_valid,
    output fwd_out, fwd_out_valid, back_out, back_out_valid, pair_count, cfg_err
  );
`endif

endinterface

// File: rtl/plug_onehot_dec.sv
// rtl/plug_onehot_dec.sv - one-hot letter to index, valid only when exactly one bit is set
module plug_onehot_dec
  import plug_pkg::*;
(
  input  logic [NUM_LETTERS-1:0] onehot,
  output letter_idx_t            idx,
  output logic                   valid
);

  localparam logic [NUM_LETTERS-1:0] ONE = 1;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (onehot[i]) idx = letter_idx_t'(i);
    end
  end

  // x & (x-1) clears the lowest set bit, so zero means at most one bit was set
  assign valid = (onehot != '0) && ((onehot & (onehot - ONE)) == '0);

endmodule

// File: rtl/plugboard_pairs.sv
// rtl/plugboard_pairs.sv - registered Steckerbrett: symmetric swap table, config FSM, fwd/back lookup
// PLUG_PENDING_EN drives the pending output with the first letter of a half-made plug.
module plugboard_pairs
  import plug_pkg::*;
#(
  parameter int MAX_PAIRS = 10
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  plugboard_pairs_if.slave  bus
);

  letter_idx_t map_q [NUM_LETTERS];
  cfg_state_t  state_q, state_d;
  letter_idx_t first_q, first_d;

  letter_idx_t fwd_idx, back_idx;
  logic        fwd_ok, back_ok;

  plug_onehot_dec u_fwd_dec (.onehot(bus.fwd_in),  .idx(fwd_idx),  .valid(fwd_ok));
  plug_onehot_dec u_back_dec(.onehot(bus.back_in), .idx(back_idx), .valid(back_ok));

  // clear_pairs swallows a same-cycle forward letter without complaint
  logic fwd_take, fwd_letter, run_fwd, run_back, in_err;
  assign fwd_take   = bus.fwd_valid && !bus.clear_pairs;
  assign fwd_letter = fwd_take && fwd_ok;
  assign run_fwd    = !bus.cfg_mode && fwd_letter;
  assign run_back   = !bus.cfg_mode && bus.back_valid && back_ok;
  assign in_err     = (fwd_take && !fwd_ok) || (!bus.cfg_mode && bus.back_valid && !back_ok);

  logic        wr_en, cnt_inc, cnt_dec, cfg_reject;
  letter_idx_t wr_a, wr_a_val, wr_b, wr_b_val;

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    wr_en      = 1'b0;
    wr_a       = fwd_idx;
    wr_a_val   = fwd_idx;
    wr_b       = fwd_idx;
    wr_b_val   = fwd_idx;
    cnt_inc    = 1'b0;
    cnt_dec    = 1'b0;
    cfg_reject = 1'b0;
    if (bus.clear_pairs || !bus.cfg_mode) begin
      state_d = IDLE;
    end else if (fwd_letter) begin
      case (state_q)
        IDLE: begin
          if (map_q[fwd_idx] != fwd_idx) begin
            // unplug both ends of the existing pair
            wr_en    = 1'b1;
            wr_b     = map_q[fwd_idx];
            wr_b_val = map_q[fwd_idx];
            cnt_dec  = 1'b1;
          end else begin
            first_d = fwd_idx;
            state_d = HAVE_FIRST;
          end
        end
        HAVE_FIRST: begin
          state_d = IDLE;
          if (fwd_idx == first_q) begin
            state_d = IDLE;
          end else if (map_q[fwd_idx] != fwd_idx || bus.pair_count == 4'(MAX_PAIRS)) begin
            cfg_reject = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_a     = first_q;
            wr_a_val = fwd_idx;
            wr_b     = fwd_idx;
            wr_b_val = first_q;
            cnt_inc  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LETTERS; i++) map_q[i] <= letter_idx_t'(i);
      bus.pair_count <= '0;
    end else if (bus.clear_pairs) begin
      for (int i = 0; i < NUM_LETTERS; i++) map_q[i] <= letter_idx_t'(i);
      bus.pair_count <= '0;
    end else begin
      if (wr_en) begin
        map_q[wr_a] <= wr_a_val;
        map_q[wr_b] <= wr_b_val;
      end
      if (cnt_inc)      bus.pair_count <= bus.pair_count + 4'd1;
      else if (cnt_dec) bus.pair_count <= bus.pair_count - 4'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bus.fwd_out        <= '0;
      bus.fwd_out_valid  <= 1'b0;
      bus.back_out       <= '0;
      bus.back_out_valid <= 1'b0;
      bus.cfg_err        <= 1'b0;
    end else begin
      bus.fwd_out_valid  <= run_fwd;
      bus.back_out_valid <= run_back;
      bus.cfg_err        <= in_err || cfg_reject;
      if (run_fwd)  bus.fwd_out  <= idx_to_onehot(map_q[fwd_idx]);
      if (run_back) bus.back_out <= idx_to_onehot(map_q[back_idx]);
    end
  end

`ifdef PLUG_PENDING_EN
  assign bus.pending = (state_q == HAVE_FIRST) ? idx_to_onehot(first_q) : '0;
`endif

endmodule
